// File: rtl/shift_pkg.sv
// Shared encodings and helpers for the pipelined barrel shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    // in_op[MODE_BIT] = 1 selects register-amount semantics, 0 immediate.
    localparam int MODE_BIT = 0;

    function automatic int pipe_latency(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered barrel-shifter level: shifts by 2**LEVEL when that amount bit is set.
module shift_stage
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int LOG    = 5,
    parameter int LEVEL  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              en,
    input  logic              in_valid,
    input  shift_type_e       in_type,
    input  logic [LOG-1:0]    in_shamt,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_carry,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output shift_type_e       out_type,
    output logic [LOG-1:0]    out_shamt,
    output logic [DATA_W-1:0] out_data,
    output logic              out_carry,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int SHIFT = 1 << LEVEL;

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] nxt_data;

    always_comb begin
        shifted = in_data;
        case (in_type)
            SH_LSL:  shifted = in_data << SHIFT;
            SH_LSR:  shifted = in_data >> SHIFT;
            SH_ASR:  shifted = DATA_W'($signed(in_data) >>> SHIFT);
            SH_ROR:  shifted = (in_data >> SHIFT) | (in_data << (DATA_W - SHIFT));
            default: shifted = in_data;
        endcase
    end

    assign nxt_data = in_shamt[LEVEL] ? shifted : in_data;

    // Carry was resolved at decode; it only rides along here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_type  <= SH_LSL;
            out_shamt <= '0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_tag   <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (en)
                out_valid <= in_valid;
            if (en) begin
                out_type  <= in_type;
                out_shamt <= in_shamt;
                out_data  <= nxt_data;
                out_carry <= in_carry;
                out_tag   <= in_tag;
            end
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: stage 0 decodes amount/type and resolves carry and
// edge cases, then log2(DATA_W) registered levels perform the actual shift.
module barrel_shift_pipe
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_carry,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_carry,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int LOG = pipe_latency(DATA_W) - 1;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipe advances unless the output holds an unaccepted result,
    // so in_ready is simply the global advance enable.
    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    shift_type_e       in_type;
    logic              msb;
    logic              amt_zero;
    logic              amt_lt_w;
    logic              amt_eq_w;
    logic [LOG-1:0]    amt_lo;
    logic [LOG-1:0]    idx_lsl;
    logic [LOG-1:0]    idx_rsh;

    assign in_type  = shift_type_e'(in_op[2:1]);
    assign msb      = in_data[DATA_W-1];
    assign amt_zero = (in_amt == '0);
    assign amt_lt_w = (in_amt < AMT_W'(DATA_W));
    assign amt_eq_w = (in_amt == AMT_W'(DATA_W));
    assign amt_lo   = in_amt[LOG-1:0];
    assign idx_lsl  = LOG'(0) - amt_lo;
    assign idx_rsh  = amt_lo - LOG'(1);

    shift_type_e       d_type;
    logic [LOG-1:0]    d_shamt;
    logic [DATA_W-1:0] d_data;
    logic              d_carry;

    // Out-of-range and zero-amount cases are folded into a substituted operand
    // with a zero shift, so the levels only ever see amounts below DATA_W.
    always_comb begin
        d_type  = SH_LSL;
        d_shamt = '0;
        d_data  = in_data;
        d_carry = in_carry;
        if (amt_zero) begin
            if (!in_op[MODE_BIT]) begin
                case (in_type)
                    SH_LSR: begin d_data = '0; d_carry = msb; end
                    SH_ASR: begin d_data = {DATA_W{msb}}; d_carry = msb; end
                    SH_ROR: begin d_data = {in_carry, in_data[DATA_W-1:1]}; d_carry = in_data[0]; end
                    default: ;
                endcase
            end
        end else begin
            case (in_type)
                SH_LSL: begin
                    if (amt_lt_w) begin
                        d_type = SH_LSL; d_shamt = amt_lo; d_carry = in_data[idx_lsl];
                    end else begin
                        d_data = '0; d_carry = amt_eq_w ? in_data[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (amt_lt_w) begin
                        d_type = SH_LSR; d_shamt = amt_lo; d_carry = in_data[idx_rsh];
                    end else begin
                        d_data = '0; d_carry = amt_eq_w ? msb : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (amt_lt_w) begin
                        d_type = SH_ASR; d_shamt = amt_lo; d_carry = in_data[idx_rsh];
                    end else begin
                        d_data = {DATA_W{msb}}; d_carry = msb;
                    end
                end
                default: begin
                    if (amt_lo == '0) begin
                        d_carry = msb;
                    end else begin
                        d_type = SH_ROR; d_shamt = amt_lo; d_carry = in_data[idx_rsh];
                    end
                end
            endcase
        end
    end

    logic              s0_valid;
    shift_type_e       s0_type;
    logic [LOG-1:0]    s0_shamt;
    logic [DATA_W-1:0] s0_data;
    logic              s0_carry;
    logic [TAG_W-1:0]  s0_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_type  <= SH_LSL;
            s0_shamt <= '0;
            s0_data  <= '0;
            s0_carry <= 1'b0;
            s0_tag   <= '0;
        end else begin
            if (flush)
                s0_valid <= 1'b0;
            else if (en)
                s0_valid <= in_valid;
            if (en) begin
                s0_type  <= d_type;
                s0_shamt <= d_shamt;
                s0_data  <= d_data;
                s0_carry <= d_carry;
                s0_tag   <= in_tag;
            end
        end
    end

    logic              st_valid [0:LOG];
    shift_type_e       st_type  [0:LOG];
    logic [LOG-1:0]    st_shamt [0:LOG];
    logic [DATA_W-1:0] st_data  [0:LOG];
    logic              st_carry [0:LOG];
    logic [TAG_W-1:0]  st_tag   [0:LOG];

    assign st_valid[0] = s0_valid;
    assign st_type[0]  = s0_type;
    assign st_shamt[0] = s0_shamt;
    assign st_data[0]  = s0_data;
    assign st_carry[0] = s0_carry;
    assign st_tag[0]   = s0_tag;

    for (genvar k = 1; k <= LOG; k++) begin : g_stage
        shift_stage #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W),
            .LOG    (LOG),
            .LEVEL  (k - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .en        (en),
            .in_valid  (st_valid[k-1]),
            .in_type   (st_type[k-1]),
            .in_shamt  (st_shamt[k-1]),
            .in_data   (st_data[k-1]),
            .in_carry  (st_carry[k-1]),
            .in_tag    (st_tag[k-1]),
            .out_valid (st_valid[k]),
            .out_type  (st_type[k]),
            .out_shamt (st_shamt[k]),
            .out_data  (st_data[k]),
            .out_carry (st_carry[k]),
            .out_tag   (st_tag[k])
        );
    end

    assign out_valid = st_valid[LOG];
    assign out_data  = st_data[LOG];
    assign out_carry = st_carry[LOG];
    assign out_tag   = st_tag[LOG];

endmodule
